// File: rtl/beam_thresh_pkg.sv
// Shared types, widths and threshold conversion for the beam threshold loader.
package beam_thresh_pkg;

  localparam int unsigned THRESH_BITS = 18;
  localparam int unsigned NBEAM_DEF   = 48;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    LOAD,
    UPDATE,
    DONE
  } state_e;

  // DSP subtractors take the negated threshold: (2^W - v) mod 2^W
  function automatic logic [THRESH_BITS-1:0] thresh_neg(input logic [THRESH_BITS-1:0] v);
    return ~v + THRESH_BITS'(1);
  endfunction

endpackage

// File: rtl/thresh_shadow_ram.sv
// Shadow threshold store: one write port, one registered read port with write-first bypass.
module thresh_shadow_ram #(
  parameter int unsigned DEPTH = 48,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 18
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_d;
  logic [DW-1:0] rd_data_q;

  // A write landing on the address being read in the same cycle is returned by that read
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_d = wr_data_i;
      end else begin
        rd_data_d = mem_q[rd_addr_i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/beam_thresh_loader.sv
// Pushes shadow beam thresholds onto the broadcast DSP threshold bus one beam at a time,
// then issues one global update so every beam switches on the same clock.
module beam_thresh_loader
  import beam_thresh_pkg::*;
#(
  parameter int unsigned NBEAM     = NBEAM_DEF,
  parameter int unsigned ADDR_BITS = $clog2(NBEAM)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_i,
  input  logic [ADDR_BITS-1:0]   wr_addr_i,
  input  logic [THRESH_BITS-1:0] wr_data_i,
  input  logic                   load_req_i,
  output logic [THRESH_BITS-1:0] thresh_o,
  output logic [NBEAM-1:0]       thresh_ce_o,
  output logic                   update_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   dirty_o
);

  localparam logic [ADDR_BITS-1:0] LAST_BEAM = ADDR_BITS'(NBEAM - 1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
  logic [NBEAM-1:0]       ce_q, ce_d;
  logic                   vld_q, vld_d;
  logic                   upd_q, upd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   dirty_q, dirty_d;
  logic                   pend_q, pend_d;

  logic                   wr_ok;
  logic                   start;
  logic                   rd_en;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [THRESH_BITS-1:0] rd_data;

  assign wr_ok = wr_i && ({1'b0, wr_addr_i} < (ADDR_BITS + 1)'(NBEAM));

  thresh_shadow_ram #(
    .DEPTH (NBEAM),
    .AW    (ADDR_BITS),
    .DW    (THRESH_BITS)
  ) u_shadow (
    .clk_i     (clk_i),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Next-state, shadow read issue (one beam ahead of the bus) and status flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ce_d    = '0;
    vld_d   = vld_q;
    upd_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dirty_d = dirty_q;
    pend_d  = pend_q;
    start   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;

    case (state_q)
      IDLE: begin
        start = load_req_i;
      end
      PRIME: begin
        pend_d  = pend_q | load_req_i;
        rd_en   = 1'b1;
        state_d = LOAD;
        cnt_d   = '0;
        ce_d    = NBEAM'(1);
        vld_d   = 1'b1;
      end
      LOAD: begin
        pend_d = pend_q | load_req_i;
        if (cnt_q == LAST_BEAM) begin
          state_d = UPDATE;
          cnt_d   = '0;
          upd_d   = 1'b1;
        end else begin
          rd_en   = 1'b1;
          rd_addr = cnt_q + ADDR_BITS'(1);
          cnt_d   = rd_addr;
          ce_d    = NBEAM'(1) << rd_addr;
        end
      end
      UPDATE: begin
        pend_d  = pend_q | load_req_i;
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      DONE: begin
        if (pend_q || load_req_i) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      state_d = PRIME;
      busy_d  = 1'b1;
      pend_d  = 1'b0;
      dirty_d = 1'b0;
    end
    // A write in the start cycle is not guaranteed to be captured, so it keeps dirty set
    if (wr_ok) begin
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ce_q    <= '0;
      vld_q   <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dirty_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      vld_q   <= vld_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dirty_q <= dirty_d;
      pend_q  <= pend_d;
    end
  end

  // Bus shows the converted registered read; zero until the first beam after reset
  assign thresh_o    = vld_q ? thresh_neg(rd_data) : '0;
  assign thresh_ce_o = ce_q;
  assign update_o    = upd_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dirty_o     = dirty_q;

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench for beam_thresh_loader: sequence timing, collisions, pending requests, reset.
module tb_beam_thresh_loader;
  import beam_thresh_pkg::*;

  localparam int unsigned NB = 48;
  localparam int unsigned AW = 6;
  localparam int unsigned TW = THRESH_BITS;

  logic          clk_i;
  logic          rst_i;
  logic          wr_i;
  logic [AW-1:0] wr_addr_i;
  logic [TW-1:0] wr_data_i;
  logic          load_req_i;
  logic [TW-1:0] thresh_o;
  logic [NB-1:0] thresh_ce_o;
  logic          update_o;
  logic          busy_o;
  logic          done_o;
  logic          dirty_o;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;
  int n_upd   = 0;
  int busy_run = 0;
  bit rst_seen = 1'b0;
  bit mon_en   = 1'b0;

  logic [TW-1:0] model [NB];
  logic [TW-1:0] expv  [NB];

  beam_thresh_loader #(.NBEAM(NB), .ADDR_BITS(AW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_i        (wr_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .load_req_i  (load_req_i),
    .thresh_o    (thresh_o),
    .thresh_ce_o (thresh_ce_o),
    .update_o    (update_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dirty_o     (dirty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] conv(input logic [TW-1:0] v);
    int unsigned x;
    x = (32'd262144 - 32'(v)) % 32'd262144;
    return TW'(x);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    t++;
  endtask

  task automatic wr(input int a, input logic [TW-1:0] d);
    wr_i      = 1'b1;
    wr_addr_i = AW'(a);
    wr_data_i = d;
    step();
    wr_i = 1'b0;
    if (a < NB) model[a] = d;
  endtask

  task automatic chk_zero_outputs(input string tag);
    check_eq({tag, "_thresh"}, 64'(thresh_o), 64'd0);
    check_eq({tag, "_ce"},     64'(thresh_ce_o), 64'd0);
    check_eq({tag, "_update"}, 64'(update_o), 64'd0);
    check_eq({tag, "_busy"},   64'(busy_o), 64'd0);
    check_eq({tag, "_done"},   64'(done_o), 64'd0);
    check_eq({tag, "_dirty"},  64'(dirty_o), 64'd0);
  endtask

  // One full load pass; optional extra request and up to two writes at given request-relative cycles
  task automatic run_seq(input string tag, input bit skip_req, input int req_at,
                         input int w1_t, input int w1_a, input logic [TW-1:0] w1_d,
                         input int w2_t, input int w2_a, input logic [TW-1:0] w2_d);
    bit            wr_seen;
    logic [NB-1:0] oh;
    wr_seen = 1'b0;
    for (int j = 0; j < NB; j++) expv[j] = model[j];
    if (!skip_req) begin
      load_req_i = 1'b1;
      t = 0;
      step();
      load_req_i = 1'b0;
    end else begin
      t = 1;
    end
    for (int c = 1; c <= int'(NB) + 3; c++) begin
      if (c == 1) begin
        check_eq($sformatf("%s_prime_busy", tag), 64'(busy_o), 64'd1);
        check_eq($sformatf("%s_prime_ce", tag), 64'(thresh_ce_o), 64'd0);
        check_eq($sformatf("%s_prime_dirty", tag), 64'(dirty_o), 64'd0);
      end else if (c <= int'(NB) + 1) begin
        oh = '0;
        oh[c-2] = 1'b1;
        check_eq($sformatf("%s_ce%0d", tag, c-2), 64'(thresh_ce_o), 64'(oh));
        check_eq($sformatf("%s_thr%0d", tag, c-2), 64'(thresh_o), 64'(conv(expv[c-2])));
        check_eq($sformatf("%s_busy%0d", tag, c-2), 64'(busy_o), 64'd1);
      end else if (c == int'(NB) + 2) begin
        check_eq($sformatf("%s_update", tag), 64'(update_o), 64'd1);
        check_eq($sformatf("%s_upd_ce", tag), 64'(thresh_ce_o), 64'd0);
        check_eq($sformatf("%s_upd_thr", tag), 64'(thresh_o), 64'(conv(expv[NB-1])));
        check_eq($sformatf("%s_upd_done", tag), 64'(done_o), 64'd0);
      end else begin
        check_eq($sformatf("%s_done", tag), 64'(done_o), 64'd1);
        check_eq($sformatf("%s_done_busy", tag), 64'(busy_o), 64'd0);
        check_eq($sformatf("%s_done_upd", tag), 64'(update_o), 64'd0);
        check_eq($sformatf("%s_done_dirty", tag), 64'(dirty_o), 64'(wr_seen));
      end
      if (c == req_at) load_req_i = 1'b1;
      if (c == w1_t) begin
        wr_i = 1'b1; wr_addr_i = AW'(w1_a); wr_data_i = w1_d;
        model[w1_a] = w1_d;
        if (c <= 1 + w1_a) expv[w1_a] = w1_d;
        wr_seen = 1'b1;
      end
      if (c == w2_t) begin
        wr_i = 1'b1; wr_addr_i = AW'(w2_a); wr_data_i = w2_d;
        model[w2_a] = w2_d;
        if (c <= 1 + w2_a) expv[w2_a] = w2_d;
        wr_seen = 1'b1;
      end
      step();
      load_req_i = 1'b0;
      wr_i       = 1'b0;
    end
  endtask

  // Protocol monitor: ce one-hot-or-zero, update never with ce, busy span per pass
  always @(negedge clk_i) begin
    if (update_o) n_upd++;
    if (mon_en) begin
      check_eq("ce_onehot0", 64'($onehot0(thresh_ce_o)), 64'd1);
      check_eq("upd_vs_ce", 64'(update_o && (|thresh_ce_o)), 64'd0);
      if (busy_o) begin
        busy_run++;
      end else if (busy_run != 0) begin
        if (!rst_seen) check_eq("busy_span", 64'(busy_run), 64'(NB + 2));
        busy_run = 0;
        rst_seen = 1'b0;
      end
    end
  end

  initial begin
    int n0;
    rst_i      = 1'b1;
    wr_i       = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    load_req_i = 1'b0;
    for (int j = 0; j < NB; j++) model[j] = '0;

    repeat (3) step();
    chk_zero_outputs("reset");
    rst_i  = 1'b0;
    mon_en = 1'b1;
    step();

    // Beam 0 = 1000 -> 0x3FC18, beam 47 = 0x3FFFF -> 0x00001, others 0
    for (int j = 0; j < int'(NB); j++) wr(j, (j == 0) ? TW'(1000) : ((j == 47) ? TW'(18'h3FFFF) : TW'(0)));
    check_eq("dirty_after_wr", 64'(dirty_o), 64'd1);
    run_seq("t1", 1'b0, -1, -1, 0, '0, -1, 0, '0);
    check_eq("t1_idle_busy", 64'(busy_o), 64'd0);
    check_eq("t1_idle_done", 64'(done_o), 64'd0);

    // Second request mid-pass queues one back-to-back pass; a late write shows up as dirty
    n0 = n_upd;
    run_seq("t2a", 1'b0, 10, 30, 10, TW'(555), -1, 0, '0);
    run_seq("t2b", 1'b1, -1, -1, 0, '0, -1, 0, '0);
    check_eq("t2_idle_busy", 64'(busy_o), 64'd0);
    check_eq("t2_updates", 64'(n_upd - n0), 64'd2);

    // Write collisions: beam5 written in its read cycle loads, beam3 written late does not
    wr(3, TW'(100));
    run_seq("t3", 1'b0, -1, 6, 5, TW'(7), 7, 3, TW'(9));
    step();
    check_eq("t3_dirty_idle", 64'(dirty_o), 64'd1);

    // Reset mid-pass: outputs clear next cycle, no update, shadow retained
    load_req_i = 1'b1;
    t = 0;
    step();
    load_req_i = 1'b0;
    while (t < 20) step();
    rst_i    = 1'b1;
    rst_seen = 1'b1;
    step();
    rst_i = 1'b0;
    chk_zero_outputs("t4_rst");
    n0 = n_upd;
    repeat (NB + 10) step();
    check_eq("t4_no_update", 64'(n_upd - n0), 64'd0);
    run_seq("t4", 1'b0, -1, -1, 0, '0, -1, 0, '0);

    // Out-of-range addresses are ignored
    step();
    wr(48, TW'(18'h1234));
    wr(63, TW'(18'h2345));
    check_eq("t5_dirty", 64'(dirty_o), 64'd0);
    run_seq("t5", 1'b0, -1, -1, 0, '0, -1, 0, '0);

    // Random writes and requests under the protocol monitor
    for (int i = 0; i < 600; i++) begin
      wr_i       = ($urandom_range(0, 3) == 0);
      wr_addr_i  = AW'($urandom_range(0, 63));
      wr_data_i  = TW'($urandom());
      load_req_i = ($urandom_range(0, 39) == 0);
      step();
    end
    wr_i       = 1'b0;
    load_req_i = 1'b0;
    repeat (2 * (NB + 4)) step();
    check_eq("rand_drain_busy", 64'(busy_o), 64'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
